// File: rtl/shift_load_ctrl.sv
// Sequencer that loads parallel words into a shift register (regWithBenefits)
// and shifts them out MSB-first, with a one-word holding buffer and abort flush.
module shift_load_ctrl #(
  parameter int   WIDTH    = 8,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] reg_d,
  output logic             reg_ld,
  output logic             reg_shl,
  output logic             reg_clr,
  output logic             reg_serialIn,
  input  logic [WIDTH-1:0] reg_q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full;
  logic [CW-1:0]    cnt;
  logic             xfer;

  assign in_ready = ~buf_full & ~abort & ~rst;
  assign xfer     = in_valid & in_ready;
  assign ser_out  = reg_q[WIDTH-1];
  assign busy     = (state != IDLE) | buf_full;

  // Outputs are registered for the state being entered, so they are Moore
  // outputs of the current state as seen by the register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      buf_q        <= '0;
      buf_full     <= 1'b0;
      cnt          <= '0;
      reg_d        <= '0;
      reg_ld       <= 1'b0;
      reg_shl      <= 1'b0;
      reg_clr      <= 1'b0;
      reg_serialIn <= 1'b0;
      ser_valid    <= 1'b0;
      word_done    <= 1'b0;
    end else begin
      reg_d        <= '0;
      reg_ld       <= 1'b0;
      reg_shl      <= 1'b0;
      reg_clr      <= 1'b0;
      reg_serialIn <= 1'b0;
      ser_valid    <= 1'b0;
      word_done    <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        buf_full <= 1'b0;
        cnt      <= '0;
        reg_clr  <= 1'b1;
      end else begin
        if (xfer) begin
          buf_q    <= in_data;
          buf_full <= 1'b1;
        end
        case (state)
          IDLE: begin
            if (buf_full) begin
              state  <= LOAD;
              reg_ld <= 1'b1;
              reg_d  <= buf_q;
            end
          end
          LOAD: begin
            buf_full     <= 1'b0;
            cnt          <= '0;
            state        <= SHIFT;
            reg_shl      <= 1'b1;
            reg_serialIn <= FILL_BIT;
            ser_valid    <= 1'b1;
          end
          SHIFT: begin
            if (cnt == LAST) begin
              state     <= DONE;
              word_done <= 1'b1;
            end else begin
              cnt          <= cnt + CW'(1);
              reg_shl      <= 1'b1;
              reg_serialIn <= FILL_BIT;
              ser_valid    <= 1'b1;
            end
          end
          DONE: begin
            // A word arriving on DONE's closing edge loads without an IDLE gap.
            if (buf_full | xfer) begin
              state  <= LOAD;
              reg_ld <= 1'b1;
              reg_d  <= buf_full ? buf_q : in_data;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench for shift_load_ctrl: directed scenarios plus random traffic against a
// slot-position reference model, with a behavioural shift register on reg_q.
module tb_shift_load_ctrl;

  localparam int   W    = 8;
  localparam logic FILL = 1'b0;

  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         abort = 1'b0;
  logic [W-1:0] reg_d;
  logic         reg_ld, reg_shl, reg_clr, reg_serialIn;
  logic [W-1:0] reg_q;
  logic         ser_out, ser_valid, busy, word_done;

  shift_load_ctrl #(.WIDTH(W), .FILL_BIT(FILL)) dut (
    .ck(ck), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .reg_d(reg_d), .reg_ld(reg_ld),
    .reg_shl(reg_shl), .reg_clr(reg_clr), .reg_serialIn(reg_serialIn),
    .reg_q(reg_q), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy),
    .word_done(word_done)
  );

  always #5 ck = ~ck;

  // Behavioural regWithBenefits.
  always_ff @(posedge ck or posedge rst) begin
    if (rst)          reg_q <= '0;
    else if (reg_clr) reg_q <= '0;
    else if (reg_ld)  reg_q <= reg_d;
    else if (reg_shl) reg_q <= {reg_q[W-2:0], reg_serialIn};
  end

  int checks = 0;
  int errors = 0;

  // Model: pos is the slot position of the word in flight
  // (-1 none, 0 load, 1..W shifting bit W-pos, W+1 done).
  int           pos = -1;
  logic [W-1:0] pend_q[$];
  logic [W-1:0] cur_word = '0;
  bit           clr_exp = 1'b0;
  bit           last_acc = 1'b0;
  int           vcount = 0;
  int           cycle = 0;
  bit           bits[$];
  int           done_cyc[$];
  int           ld_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos = -1;
    pend_q.delete();
    clr_exp = 1'b0;
    vcount = 0;
  endtask

  task automatic model_step(input bit v, input logic [W-1:0] d, input bit a);
    bit had;
    had = (pend_q.size() != 0);
    last_acc = 1'b0;
    if (a) begin
      pos = -1;
      pend_q.delete();
      clr_exp = 1'b1;
      vcount = 0;
    end else begin
      clr_exp = 1'b0;
      last_acc = v && !had;
      if (last_acc) pend_q.push_back(d);
      if (pos == -1) begin
        if (had) pos = 0;
      end else if (pos == 0) begin
        cur_word = pend_q.pop_front();
        pos = 1;
      end else if (pos <= W) begin
        pos++;
      end else begin
        pos = (pend_q.size() != 0) ? 0 : -1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("ld", reg_ld, pos == 0);
    if (pos == 0) chk("reg_d", reg_d, pend_q[0]);
    chk("shl", reg_shl, pos >= 1 && pos <= W);
    chk("ser_valid", ser_valid, pos >= 1 && pos <= W);
    chk("word_done", word_done, pos == W + 1);
    chk("clr", reg_clr, clr_exp);
    chk("busy", busy, pos != -1 || pend_q.size() != 0);
    chk("excl", $countones({reg_ld, reg_shl, reg_clr}) <= 1, 1);
    if (pos >= 1 && pos <= W) begin
      chk("ser_out", ser_out, cur_word[W-pos]);
      chk("serialIn", reg_serialIn, FILL);
    end
    if (pos == W + 1) chk("q_after_word", reg_q, {W{FILL}});
    if (ser_valid === 1'b1) begin
      vcount++;
      bits.push_back(ser_out);
    end
    if (reg_ld === 1'b1) ld_cyc.push_back(cycle);
    if (word_done === 1'b1) begin
      chk("valid_bits_per_word", vcount, W);
      vcount = 0;
      done_cyc.push_back(cycle);
    end
  endtask

  // Drive one cycle of inputs, cross the edge, update model, check.
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit a);
    in_valid = v;
    in_data  = d;
    abort    = a;
    #1;
    chk("in_ready", in_ready, pend_q.size() == 0 && !a);
    @(posedge ck);
    #1;
    cycle++;
    model_step(v, d, a);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic clear_logs();
    bits.delete();
    done_cyc.delete();
    ld_cyc.delete();
  endtask

  function automatic logic [31:0] bits_val(input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n && i < bits.size(); i++) r = {r[30:0], bits[i]};
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"}, {reg_d, reg_ld, reg_shl, reg_clr, ser_valid, word_done, busy}, '0);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
  endtask

  int n_acc;
  int guard;

  initial begin
    // Reset state.
    #2;
    check_reset_outputs("reset");
    @(negedge ck);
    rst = 1'b0;
    model_reset();

    // Single word A5.
    clear_logs();
    cyc(1'b1, 8'hA5, 1'b0);
    chk("a5_accept", last_acc, 1'b1);
    n_acc = cycle;
    idle(11);
    chk("a5_ld_cycle", ld_cyc.size() > 0 ? ld_cyc[0] : -1, n_acc + 1);
    chk("a5_done_cycle", done_cyc.size() > 0 ? done_cyc[0] : -1, n_acc + 10);
    chk("a5_nbits", bits.size(), 8);
    chk("a5_bits", bits_val(8), 32'hA5);
    chk("a5_q_zero", reg_q, 8'h00);

    // Back-to-back 81 then 3C.
    clear_logs();
    cyc(1'b1, 8'h81, 1'b0);
    guard = 0;
    do begin
      cyc(1'b1, 8'h3C, 1'b0);
      guard++;
    end while (!last_acc && guard < 20);
    chk("b2b_second_accept", last_acc, 1'b1);
    idle(24);
    chk("b2b_nbits", bits.size(), 16);
    chk("b2b_bits", bits_val(16), 32'h813C);
    chk("b2b_ndone", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("b2b_spacing", done_cyc[1] - done_cyc[0], 10);

    // Abort on 4th SHIFT cycle of FF with 0F buffered.
    clear_logs();
    cyc(1'b1, 8'hFF, 1'b0);
    guard = 0;
    do begin
      cyc(1'b1, 8'h0F, 1'b0);
      guard++;
    end while (!last_acc && guard < 20);
    chk("abort_buffered", last_acc, 1'b1);
    guard = 0;
    while (pos != 4 && guard < 20) begin
      cyc(1'b0, '0, 1'b0);
      guard++;
    end
    chk("abort_reach_shift4", pos, 4);
    cyc(1'b0, '0, 1'b1);
    chk("abort_clr", reg_clr, 1'b1);
    chk("abort_busy", busy, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("abort_q_zero", reg_q, 8'h00);
    idle(12);
    chk("abort_no_done", done_cyc.size(), 0);

    // Multi-cycle abort: one clr per abort cycle.
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // in_valid together with abort: no transfer, accepted next cycle.
    cyc(1'b1, 8'h55, 1'b1);
    chk("abort_valid_no_xfer", last_acc, 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    chk("abort_valid_next", last_acc, 1'b1);
    idle(12);

    // Async reset mid-SHIFT, then 01.
    clear_logs();
    cyc(1'b1, 8'h66, 1'b0);
    idle(4);
    chk("rst_in_shift", pos, 3);
    @(negedge ck);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge ck);
    @(negedge ck);
    rst = 1'b0;
    model_reset();
    clear_logs();
    cyc(1'b1, 8'h01, 1'b0);
    idle(11);
    chk("rst_no_done", done_cyc.size(), 1);
    chk("rst_bits", bits_val(8), 32'h01);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 19) == 0));
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
